// File: rtl/wb_gpio_ctrl_multi.sv
// Wishbone GPIO controller: per-pin output/direction registers with atomic set/clear/toggle,
// synchronised and optionally debounced inputs, and per-pin level/edge interrupts merged into one IRQ.
module wb_gpio_ctrl_multi #(
  parameter int          GPIO_WIDTH  = 32,
  parameter int          ADDRWIDTH   = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          DB_WIDTH    = 16,
  parameter logic [31:0] ID_VALUE    = 32'hA5A5_0102
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST,
  input  logic [ADDRWIDTH-1:0]  WBs_ADR,
  input  logic                  WBs_CYC,
  input  logic                  WBs_STB,
  input  logic                  WBs_WE,
  input  logic [3:0]            WBs_BYTE_STB,
  input  logic [31:0]           WBs_WR_DAT,
  output logic [31:0]           WBs_RD_DAT,
  output logic                  WBs_ACK,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN_i,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT_o,
  output logic [GPIO_WIDTH-1:0] GPIO_OE_o,
  output logic                  GPIO_INT_o
);

  localparam logic [ADDRWIDTH-1:0] IDX_IN       = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] IDX_OUT      = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] IDX_OE       = ADDRWIDTH'(2);
  localparam logic [ADDRWIDTH-1:0] IDX_INT_EN   = ADDRWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] IDX_INT_TYPE = ADDRWIDTH'(4);
  localparam logic [ADDRWIDTH-1:0] IDX_INT_POL  = ADDRWIDTH'(5);
  localparam logic [ADDRWIDTH-1:0] IDX_INT_STAT = ADDRWIDTH'(6);
  localparam logic [ADDRWIDTH-1:0] IDX_OUT_SET  = ADDRWIDTH'(7);
  localparam logic [ADDRWIDTH-1:0] IDX_OUT_CLR  = ADDRWIDTH'(8);
  localparam logic [ADDRWIDTH-1:0] IDX_OUT_TGL  = ADDRWIDTH'(9);
  localparam logic [ADDRWIDTH-1:0] IDX_DEBOUNCE = ADDRWIDTH'(10);
  localparam logic [ADDRWIDTH-1:0] IDX_ID       = ADDRWIDTH'(11);

  logic                  ack_q;
  logic [31:0]           rd_q;
  logic [31:0]           rd_mux;
  logic                  bus_acc;
  logic                  wr_acc;
  logic [31:0]           byte_mask;
  logic [GPIO_WIDTH-1:0] wmask;
  logic [GPIO_WIDTH-1:0] wdat;
  logic [DB_WIDTH-1:0]   db_mask;
  logic [DB_WIDTH-1:0]   db_wdat;

  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] oe_q;
  logic [GPIO_WIDTH-1:0] int_en_q;
  logic [GPIO_WIDTH-1:0] int_type_q;
  logic [GPIO_WIDTH-1:0] int_pol_q;
  logic [GPIO_WIDTH-1:0] stat_q;
  logic [DB_WIDTH-1:0]   db_cfg_q;
  logic [DB_WIDTH-1:0]   presc_q;

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] sync_in;
  logic [GPIO_WIDTH-1:0] sample_q;
  logic [GPIO_WIDTH-1:0] deb_q;
  logic [GPIO_WIDTH-1:0] deb_in;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] stable;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] edge_hit;
  logic [GPIO_WIDTH-1:0] level_live;
  logic [GPIO_WIDTH-1:0] stat_rd;
  logic [GPIO_WIDTH-1:0] w1c;
  logic                  irq_q;
  logic                  db_on;
  logic                  tick;

  logic wr_out, wr_oe, wr_en, wr_type, wr_pol, wr_stat, wr_set, wr_clr, wr_tgl, wr_db;

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old_v,
                                                  input logic [GPIO_WIDTH-1:0] new_v,
                                                  input logic [GPIO_WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Bus handshake: the access is committed on the edge that raises ACK.
  assign bus_acc   = WBs_CYC & WBs_STB & ~ack_q;
  assign wr_acc    = bus_acc & WBs_WE;
  assign byte_mask = {{8{WBs_BYTE_STB[3]}}, {8{WBs_BYTE_STB[2]}},
                      {8{WBs_BYTE_STB[1]}}, {8{WBs_BYTE_STB[0]}}};
  assign wmask     = byte_mask[GPIO_WIDTH-1:0];
  assign wdat      = WBs_WR_DAT[GPIO_WIDTH-1:0] & wmask;
  assign db_mask   = byte_mask[DB_WIDTH-1:0];
  assign db_wdat   = WBs_WR_DAT[DB_WIDTH-1:0];

  assign wr_out  = wr_acc && (WBs_ADR == IDX_OUT);
  assign wr_oe   = wr_acc && (WBs_ADR == IDX_OE);
  assign wr_en   = wr_acc && (WBs_ADR == IDX_INT_EN);
  assign wr_type = wr_acc && (WBs_ADR == IDX_INT_TYPE);
  assign wr_pol  = wr_acc && (WBs_ADR == IDX_INT_POL);
  assign wr_stat = wr_acc && (WBs_ADR == IDX_INT_STAT);
  assign wr_set  = wr_acc && (WBs_ADR == IDX_OUT_SET);
  assign wr_clr  = wr_acc && (WBs_ADR == IDX_OUT_CLR);
  assign wr_tgl  = wr_acc && (WBs_ADR == IDX_OUT_TGL);
  assign wr_db   = wr_acc && (WBs_ADR == IDX_DEBOUNCE);

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      ack_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      ack_q <= bus_acc;
      rd_q  <= (bus_acc && !WBs_WE) ? rd_mux : '0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      out_q      <= '0;
      oe_q       <= '0;
      int_en_q   <= '0;
      int_type_q <= '0;
      int_pol_q  <= '0;
      db_cfg_q   <= '0;
    end else begin
      if (wr_out)      out_q <= merge(out_q, wdat, wmask);
      else if (wr_set) out_q <= out_q | wdat;
      else if (wr_clr) out_q <= out_q & ~wdat;
      else if (wr_tgl) out_q <= out_q ^ wdat;
      if (wr_oe)   oe_q       <= merge(oe_q, wdat, wmask);
      if (wr_en)   int_en_q   <= merge(int_en_q, wdat, wmask);
      if (wr_type) int_type_q <= merge(int_type_q, wdat, wmask);
      if (wr_pol)  int_pol_q  <= merge(int_pol_q, wdat, wmask);
      if (wr_db)   db_cfg_q   <= (db_cfg_q & ~db_mask) | (db_wdat & db_mask);
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= GPIO_IN_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Prescaler runs 0..N-1 and ticks on N-1; idle at 0 while debounce is bypassed.
  assign db_on = (db_cfg_q != '0);
  assign tick  = db_on && (presc_q == (db_cfg_q - DB_WIDTH'(1)));

  always_ff @(posedge WB_CLK) begin
    if (WB_RST)                presc_q <= '0;
    else if (wr_db)            presc_q <= '0;
    else if (!db_on || tick)   presc_q <= '0;
    else                       presc_q <= presc_q + DB_WIDTH'(1);
  end

  // While bypassed the filter tracks sync_in so enabling debounce causes no spurious edge.
  assign stable = ~(sync_in ^ sample_q);

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      deb_q    <= '0;
      sample_q <= '0;
    end else if (!db_on) begin
      deb_q    <= sync_in;
      sample_q <= sync_in;
    end else if (tick) begin
      deb_q    <= (deb_q & ~stable) | (sync_in & stable);
      sample_q <= sync_in;
    end
  end

  assign deb_in = db_on ? deb_q : sync_in;

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) prev_q <= '0;
    else        prev_q <= deb_in;
  end

  assign rise       = deb_in & ~prev_q;
  assign fall       = ~deb_in & prev_q;
  assign edge_hit   = int_en_q & int_type_q & ((int_pol_q & rise) | (~int_pol_q & fall));
  assign level_live = int_en_q & ~(deb_in ^ int_pol_q);
  assign stat_rd    = (int_type_q & stat_q) | (~int_type_q & level_live);
  assign w1c        = wr_stat ? (wdat & int_type_q) : '0;

  // A new edge in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) stat_q <= '0;
    else        stat_q <= (stat_q & ~w1c) | edge_hit;
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) irq_q <= 1'b0;
    else        irq_q <= |(stat_rd & int_en_q);
  end

  always_comb begin
    rd_mux = '0;
    case (WBs_ADR)
      IDX_IN:       rd_mux = 32'(deb_in);
      IDX_OUT:      rd_mux = 32'(out_q);
      IDX_OE:       rd_mux = 32'(oe_q);
      IDX_INT_EN:   rd_mux = 32'(int_en_q);
      IDX_INT_TYPE: rd_mux = 32'(int_type_q);
      IDX_INT_POL:  rd_mux = 32'(int_pol_q);
      IDX_INT_STAT: rd_mux = 32'(stat_rd);
      IDX_DEBOUNCE: rd_mux = 32'(db_cfg_q);
      IDX_ID:       rd_mux = ID_VALUE;
      default:      rd_mux = '0;
    endcase
  end

  assign WBs_ACK    = ack_q;
  assign WBs_RD_DAT = rd_q;
  assign GPIO_OUT_o = out_q;
  assign GPIO_OE_o  = oe_q;
  assign GPIO_INT_o = irq_q;

endmodule
